// File: rtl/lfsr_pkg.sv
// Shared constants, state encoding and step function
// for the 5-bit test-pattern LFSR.
package lfsr_pkg;

  localparam int LFSR_W = 5;

  localparam logic [LFSR_W-1:0] LFSR_TAP = 5'b00100;
  localparam logic [LFSR_W-1:0] LFSR_SAFE_SEED = 5'b00001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Internal-XOR form of x^5+x^2+1: rotate left, fold s[4] into the tap
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], s[LFSR_W-1]}
         ^ ({LFSR_W{s[LFSR_W-1]}} & LFSR_TAP);
  endfunction

endpackage

// File: rtl/lfsr5_core.sv
// 5-bit LFSR register with runtime load; load beats step.
// Resets to the safe nonzero seed.
module lfsr5_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= LFSR_SAFE_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_pattern_sched.sv
// Run sequencer: streams count LFSR patterns over
// valid/ready, then pulses done (or aborted).
module lfsr_pattern_sched
  import lfsr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  input  logic              pat_ready,
  output logic              pat_valid,
  output logic [LFSR_W-1:0] pat_data,
  output logic              pat_last,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              seed_fix
);

  sched_state_e state_q;
  sched_state_e state_d;

  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;

  logic aborted_q;
  logic aborted_d;
  logic seed_fix_q;
  logic seed_fix_d;

  logic              lfsr_load;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_seed;
  logic [LFSR_W-1:0] lfsr_q;

  logic seed_zero;
  logic in_run;
  logic xfer;
  logic rem_one;

  assign seed_zero = (seed == '0);
  assign in_run    = (state_q == RUN);
  assign xfer      = in_run & pat_ready;
  assign rem_one   = (rem_q == CNT_W'(1));
  assign lfsr_seed = seed_zero ? LFSR_SAFE_SEED : seed;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    aborted_d  = 1'b0;
    seed_fix_d = seed_fix_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_load  = 1'b1;
          rem_d      = count;
          seed_fix_d = seed_zero;
          state_d    = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          lfsr_step = 1'b1;
          rem_d     = rem_q - CNT_W'(1);
          if (rem_one) begin
            state_d = DONE;
          end
        end
        // abort overrides a final transfer: no done pulse
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      aborted_q  <= 1'b0;
      seed_fix_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      aborted_q  <= aborted_d;
      seed_fix_q <= seed_fix_d;
    end
  end

  lfsr5_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_seed),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  assign pat_valid = in_run;
  assign pat_data  = lfsr_q;
  assign pat_last  = in_run & rem_one;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign aborted   = aborted_q;
  assign seed_fix  = seed_fix_q;

endmodule
